// File: rtl/conv_encoder_k_param.sv
// Rate-1/2 feed-forward convolutional encoder with parametrised constraint length
// and generators, valid/ready bit input, valid/ready 2-bit symbol output, optional zero tail.
module conv_encoder_k_param #(
   parameter int           K  = 5,
   parameter logic [K-1:0] G1 = 5'b11101,
   parameter logic [K-1:0] G0 = 5'b10011
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       in_bit,
   input  logic       in_last,
   input  logic       term_en,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [1:0] out_sym,
   output logic       out_last
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
   // a producer holding valid keeps its payload stable until that edge.
   localparam int TW = $clog2(K);

   typedef enum logic {RUN, FLUSH} fsm_t;

   fsm_t            fsm_q, fsm_d;
   logic [K-2:0]    state_q, state_d;
   logic [TW-1:0]   tail_cnt_q, tail_cnt_d;
   logic            out_valid_q, out_valid_d;
   logic [1:0]      out_sym_q, out_sym_d;
   logic            out_last_q, out_last_d;

   logic            slot_free;
   logic            enc_bit;
   logic [K-1:0]    v;
   logic [1:0]      sym;

   always_comb begin
      slot_free   = !out_valid_q || out_ready;
      enc_bit     = (fsm_q == RUN) ? in_bit : 1'b0;
      v           = {enc_bit, state_q};
      sym         = {^(v & G1), ^(v & G0)};

      fsm_d       = fsm_q;
      state_d     = state_q;
      tail_cnt_d  = tail_cnt_q;
      out_valid_d = out_valid_q;
      out_sym_d   = out_sym_q;
      out_last_d  = out_last_q;
      in_ready    = 1'b0;

      // A consumed symbol empties the register unless a new one is loaded below.
      if (out_ready) out_valid_d = 1'b0;

      case (fsm_q)
         RUN: begin
            in_ready = slot_free && !rst;
            if (in_valid && slot_free) begin
               out_valid_d = 1'b1;
               out_sym_d   = sym;
               state_d     = {in_bit, state_q[K-2:1]};
               out_last_d  = 1'b0;
               if (in_last && term_en) begin
                  fsm_d      = FLUSH;
                  tail_cnt_d = TW'(K-1);
               end else if (in_last) begin
                  out_last_d = 1'b1;
                  state_d    = '0;
               end
            end
         end
         FLUSH: begin
            if (slot_free) begin
               out_valid_d = 1'b1;
               out_sym_d   = sym;
               state_d     = {1'b0, state_q[K-2:1]};
               tail_cnt_d  = tail_cnt_q - TW'(1);
               out_last_d  = (tail_cnt_q == TW'(1));
               if (tail_cnt_q == TW'(1)) fsm_d = RUN;
            end
         end
         default: fsm_d = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fsm_q       <= RUN;
         state_q     <= '0;
         tail_cnt_q  <= '0;
         out_valid_q <= 1'b0;
         out_sym_q   <= 2'b00;
         out_last_q  <= 1'b0;
      end else begin
         fsm_q       <= fsm_d;
         state_q     <= state_d;
         tail_cnt_q  <= tail_cnt_d;
         out_valid_q <= out_valid_d;
         out_sym_q   <= out_sym_d;
         out_last_q  <= out_last_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_sym   = out_sym_q;
   assign out_last  = out_last_q;

endmodule

// File: tb/tb_conv_encoder_k_param.sv
// Bench for conv_encoder_k_param: a K=5 default instance for directed scenarios and a
// K=7 instance for random frames, both checked against an independent tap-sum model.
module tb_conv_encoder_k_param;

   localparam logic [8:0] A_G1 = 9'b000011101;
   localparam logic [8:0] A_G0 = 9'b000010011;
   localparam logic [8:0] B_G1 = 9'b001111001;
   localparam logic [8:0] B_G0 = 9'b001011011;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic       a_in_valid = 1'b0, a_in_bit = 1'b0, a_in_last = 1'b0, a_term_en = 1'b0;
   logic       a_out_ready = 1'b1;
   logic       a_in_ready, a_out_valid, a_out_last;
   logic [1:0] a_out_sym;

   logic       b_in_valid = 1'b0, b_in_bit = 1'b0, b_in_last = 1'b0, b_term_en = 1'b0;
   logic       b_out_ready = 1'b1;
   logic       b_in_ready, b_out_valid, b_out_last;
   logic [1:0] b_out_sym;
   logic       b_rand_rdy = 1'b0;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   logic [2:0] a_exp_q[$];
   logic [2:0] b_exp_q[$];
   int         b_len_q[$];
   int         b_len_exp_q[$];
   logic [7:0] a_hist = '0;
   logic [7:0] b_hist = '0;
   int         b_frame_syms = 0;

   conv_encoder_k_param dut_a (
      .clk(clk), .rst(rst),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_bit(a_in_bit),
      .in_last(a_in_last), .term_en(a_term_en),
      .out_valid(a_out_valid), .out_ready(a_out_ready),
      .out_sym(a_out_sym), .out_last(a_out_last)
   );

   conv_encoder_k_param #(.K(7), .G1(7'b1111001), .G0(7'b1011011)) dut_b (
      .clk(clk), .rst(rst),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_bit(b_in_bit),
      .in_last(b_in_last), .term_en(b_term_en),
      .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_sym(b_out_sym), .out_last(b_out_last)
   );

   always #5 clk = ~clk;

   // Output bit = XOR over delays j of G[k-1-j] & x[n-j]; hist[0] is the newest past bit.
   function automatic logic [1:0] model_sym(input int k, input logic [8:0] g1,
                                            input logic [8:0] g0, input logic b,
                                            input logic [7:0] hist);
      logic p1, p0;
      p1 = g1[k-1] & b;
      p0 = g0[k-1] & b;
      for (int j = 1; j < k; j++) begin
         p1 = p1 ^ (g1[k-1-j] & hist[j-1]);
         p0 = p0 ^ (g0[k-1-j] & hist[j-1]);
      end
      return {p1, p0};
   endfunction

   // Scoreboard for instance A: push on accepted input, pop on taken output.
   logic [1:0] a_s;
   logic [2:0] a_e;
   always @(negedge clk) begin
      if (!rst) begin
         if (a_in_valid && a_in_ready) begin
            a_s = model_sym(5, A_G1, A_G0, a_in_bit, a_hist);
            a_hist = {a_hist[6:0], a_in_bit};
            if (a_in_last && a_term_en) begin
               a_exp_q.push_back({1'b0, a_s});
               for (int t = 1; t < 5; t++) begin
                  a_s = model_sym(5, A_G1, A_G0, 1'b0, a_hist);
                  a_hist = {a_hist[6:0], 1'b0};
                  a_exp_q.push_back({(t == 4), a_s});
               end
            end else if (a_in_last) begin
               a_exp_q.push_back({1'b1, a_s});
               a_hist = '0;
            end else begin
               a_exp_q.push_back({1'b0, a_s});
            end
         end
         if (a_out_valid && a_out_ready) begin
            chk_cnt++;
            if (a_exp_q.size() == 0) begin
               $display("FAIL sb_a: unexpected symbol last/sym=%b, queue empty", {a_out_last, a_out_sym});
            end else begin
               a_e = a_exp_q.pop_front();
               if ({a_out_last, a_out_sym} !== a_e)
                  $display("FAIL sb_a: last/sym got %b expected %b", {a_out_last, a_out_sym}, a_e);
               else pass_cnt++;
            end
         end
      end
   end

   // Scoreboard for instance B, also recording per-frame symbol counts.
   logic [1:0] b_s;
   logic [2:0] b_e;
   always @(negedge clk) begin
      if (!rst) begin
         if (b_in_valid && b_in_ready) begin
            b_s = model_sym(7, B_G1, B_G0, b_in_bit, b_hist);
            b_hist = {b_hist[6:0], b_in_bit};
            if (b_in_last && b_term_en) begin
               b_exp_q.push_back({1'b0, b_s});
               for (int t = 1; t < 7; t++) begin
                  b_s = model_sym(7, B_G1, B_G0, 1'b0, b_hist);
                  b_hist = {b_hist[6:0], 1'b0};
                  b_exp_q.push_back({(t == 6), b_s});
               end
            end else if (b_in_last) begin
               b_exp_q.push_back({1'b1, b_s});
               b_hist = '0;
            end else begin
               b_exp_q.push_back({1'b0, b_s});
            end
         end
         if (b_out_valid && b_out_ready) begin
            chk_cnt++;
            b_frame_syms++;
            if (b_out_last) begin
               b_len_q.push_back(b_frame_syms);
               b_frame_syms = 0;
            end
            if (b_exp_q.size() == 0) begin
               $display("FAIL sb_b: unexpected symbol last/sym=%b, queue empty", {b_out_last, b_out_sym});
            end else begin
               b_e = b_exp_q.pop_front();
               if ({b_out_last, b_out_sym} !== b_e)
                  $display("FAIL sb_b: last/sym got %b expected %b", {b_out_last, b_out_sym}, b_e);
               else pass_cnt++;
            end
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (b_rand_rdy) b_out_ready = 1'($urandom_range(0, 1));
      else            b_out_ready = 1'b1;
   end

   task automatic do_reset();
      rst = 1'b1;
      a_exp_q.delete();
      b_exp_q.delete();
      a_hist = '0;
      b_hist = '0;
      b_frame_syms = 0;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic send_a(input logic b, input logic last, input logic term);
      bit got = 0;
      a_in_valid = 1'b1; a_in_bit = b; a_in_last = last; a_term_en = term;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         if (a_in_ready) got = 1;
         @(posedge clk); #1;
      end
      a_in_valid = 1'b0;
      if (!got) begin
         chk_cnt++;
         $display("FAIL send_a_timeout: in_ready got 0 expected 1 within 200 cycles");
      end
   endtask

   task automatic send_b(input logic b, input logic last, input logic term);
      bit got = 0;
      b_in_valid = 1'b1; b_in_bit = b; b_in_last = last; b_term_en = term;
      for (int i = 0; i < 400 && !got; i++) begin
         @(negedge clk);
         if (b_in_ready) got = 1;
         @(posedge clk); #1;
      end
      b_in_valid = 1'b0;
      if (!got) begin
         chk_cnt++;
         $display("FAIL send_b_timeout: in_ready got 0 expected 1 within 400 cycles");
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      chk_cnt += 4;
      if (a_out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", a_out_valid); else pass_cnt++;
      if (a_out_sym !== 2'b00)  $display("FAIL reset_out_sym: got %b expected 00", a_out_sym); else pass_cnt++;
      if (a_out_last !== 1'b0)  $display("FAIL reset_out_last: got %b expected 0", a_out_last); else pass_cnt++;
      if (a_in_ready !== 1'b1)  $display("FAIL reset_in_ready: got %b expected 1", a_in_ready); else pass_cnt++;
      @(posedge clk); #1;
   endtask

   task automatic test_term_single();
      logic [1:0] exp1[5] = '{2'b11, 2'b10, 2'b10, 2'b01, 2'b11};
      a_out_ready = 1'b1;
      send_a(1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk_cnt++;
         if (a_out_valid !== 1'b1 || a_out_sym !== exp1[i] || a_out_last !== (i == 4))
            $display("FAIL term_sym%0d: valid/last/sym got %b/%b/%b expected 1/%b/%b",
                     i, a_out_valid, a_out_last, a_out_sym, (i == 4), exp1[i]);
         else pass_cnt++;
         if (i < 4) begin
            chk_cnt++;
            if (a_in_ready !== 1'b0) $display("FAIL term_in_ready%0d: got %b expected 0", i, a_in_ready);
            else pass_cnt++;
         end
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk_cnt++;
      if (a_out_valid !== 1'b0) $display("FAIL term_idle: out_valid got %b expected 0", a_out_valid);
      else pass_cnt++;
      @(posedge clk); #1;
   endtask

   task automatic test_truncated();
      logic       bits[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      logic       lasts[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      logic [1:0] exps[5]  = '{2'b11, 2'b10, 2'b01, 2'b00, 2'b11};
      a_out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         send_a(bits[i], lasts[i], 1'b0);
         @(negedge clk);
         chk_cnt++;
         if (a_out_valid !== 1'b1 || a_out_sym !== exps[i] || a_out_last !== lasts[i])
            $display("FAIL trunc_sym%0d: valid/last/sym got %b/%b/%b expected 1/%b/%b",
                     i, a_out_valid, a_out_last, a_out_sym, lasts[i], exps[i]);
         else pass_cnt++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_backpressure();
      logic [1:0] exp1[5] = '{2'b11, 2'b10, 2'b10, 2'b01, 2'b11};
      logic [3:0] pat = 4'b1001;
      logic [1:0] taken[$];
      logic [2:0] held = '0;
      bit         holding = 0;
      a_out_ready = 1'b1;
      send_a(1'b1, 1'b1, 1'b1);
      for (int c = 0; c < 40 && taken.size() < 5; c++) begin
         a_out_ready = (c < 4) ? pat[3-c] : 1'b1;
         @(negedge clk);
         if (holding) begin
            chk_cnt++;
            if (a_out_valid !== 1'b1 || {a_out_last, a_out_sym} !== held)
               $display("FAIL bp_hold: valid/last/sym got %b/%b expected 1/%b",
                        a_out_valid, {a_out_last, a_out_sym}, held);
            else pass_cnt++;
         end
         holding = a_out_valid && !a_out_ready;
         held    = {a_out_last, a_out_sym};
         if (a_out_valid && a_out_ready) taken.push_back(a_out_sym);
         @(posedge clk); #1;
      end
      a_out_ready = 1'b1;
      chk_cnt++;
      if (taken.size() != 5) $display("FAIL bp_count: got %0d symbols expected 5", taken.size());
      else begin
         pass_cnt++;
         for (int i = 0; i < 5; i++) begin
            chk_cnt++;
            if (taken[i] !== exp1[i]) $display("FAIL bp_sym%0d: got %b expected %b", i, taken[i], exp1[i]);
            else pass_cnt++;
         end
      end
   endtask

   task automatic test_reset_flush();
      a_out_ready = 1'b1;
      send_a(1'b1, 1'b1, 1'b1);
      repeat (3) begin
         @(negedge clk);
         @(posedge clk); #1;
      end
      do_reset();
      @(negedge clk);
      chk_cnt += 3;
      if (a_out_valid !== 1'b0) $display("FAIL rstflush_out_valid: got %b expected 0", a_out_valid); else pass_cnt++;
      if (a_out_last !== 1'b0)  $display("FAIL rstflush_out_last: got %b expected 0", a_out_last); else pass_cnt++;
      if (a_in_ready !== 1'b1)  $display("FAIL rstflush_in_ready: got %b expected 1", a_in_ready); else pass_cnt++;
      @(posedge clk); #1;
      send_a(1'b1, 1'b1, 1'b0);
      @(negedge clk);
      chk_cnt++;
      if (a_out_valid !== 1'b1 || a_out_sym !== 2'b11)
         $display("FAIL rstflush_first: valid/sym got %b/%b expected 1/11", a_out_valid, a_out_sym);
      else pass_cnt++;
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      int accepts = 0, frames = 0, n = 0;
      a_out_ready = 1'b1;
      a_in_valid = 1'b1; a_in_bit = 1'b1; a_in_last = 1'b1; a_term_en = 1'b1;
      for (int c = 0; c < 60 && frames < 3; c++) begin
         @(negedge clk);
         if (a_in_valid && a_in_ready) accepts++;
         if (a_out_valid && a_out_ready) begin
            n++;
            if (a_out_last) begin
               chk_cnt++;
               if (n != 5) $display("FAIL b2b_frame%0d: got %0d symbols expected 5", frames, n);
               else pass_cnt++;
               frames++;
               n = 0;
            end
         end
         @(posedge clk); #1;
         if (accepts >= 3) a_in_valid = 1'b0;
      end
      a_in_valid = 1'b0;
      chk_cnt++;
      if (frames != 3) $display("FAIL b2b_frames: got %0d frames expected 3", frames);
      else pass_cnt++;
   endtask

   task automatic test_random_k7();
      logic term;
      bit   drained = 0;
      b_rand_rdy = 1'b1;
      for (int f = 0; f < 4; f++) begin
         term = (f < 2) ? 1'b1 : 1'($urandom_range(0, 1));
         b_len_exp_q.push_back(term ? 70 : 64);
         for (int i = 0; i < 64; i++) begin
            repeat ($urandom_range(0, 2)) begin
               @(posedge clk); #1;
            end
            send_b(1'($urandom_range(0, 1)), (i == 63),
                   (i == 63) ? term : 1'($urandom_range(0, 1)));
         end
      end
      for (int c = 0; c < 3000 && !drained; c++) begin
         @(negedge clk);
         if (b_exp_q.size() == 0) drained = 1;
         @(posedge clk); #1;
      end
      b_rand_rdy = 1'b0;
      chk_cnt++;
      if (!drained) $display("FAIL k7_drain: %0d symbols outstanding expected 0", b_exp_q.size());
      else pass_cnt++;
      chk_cnt++;
      if (b_len_q.size() != b_len_exp_q.size())
         $display("FAIL k7_frames: got %0d frames expected %0d", b_len_q.size(), b_len_exp_q.size());
      else begin
         pass_cnt++;
         for (int i = 0; i < b_len_q.size(); i++) begin
            chk_cnt++;
            if (b_len_q[i] != b_len_exp_q[i])
               $display("FAIL k7_len%0d: got %0d symbols expected %0d", i, b_len_q[i], b_len_exp_q[i]);
            else pass_cnt++;
         end
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      do_reset();
      test_reset();
      test_term_single();
      test_truncated();
      test_backpressure();
      test_reset_flush();
      test_back_to_back();
      test_random_k7();
      repeat (3) @(posedge clk);
      chk_cnt++;
      if (a_exp_q.size() != 0) $display("FAIL a_drain: %0d symbols outstanding expected 0", a_exp_q.size());
      else pass_cnt++;
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
